// File: rtl/rv_pkg.sv
// Shared RV32I constants for the program loader: command kinds, opcodes and
// immediate range limits, plus the kind-to-opcode lookup.
package rv_pkg;

  typedef enum logic [3:0] {
    K_R       = 4'd0,
    K_I_ARITH = 4'd1,
    K_LOAD    = 4'd2,
    K_STORE   = 4'd3,
    K_BRANCH  = 4'd4,
    K_JAL     = 4'd5,
    K_JALR    = 4'd6,
    K_LUI     = 4'd7,
    K_AUIPC   = 4'd8,
    K_SYSTEM  = 4'd9
  } kind_e;

  localparam logic [6:0] OP_R       = 7'h33;
  localparam logic [6:0] OP_I_ARITH = 7'h13;
  localparam logic [6:0] OP_LOAD    = 7'h03;
  localparam logic [6:0] OP_STORE   = 7'h23;
  localparam logic [6:0] OP_BRANCH  = 7'h63;
  localparam logic [6:0] OP_JAL     = 7'h6F;
  localparam logic [6:0] OP_JALR    = 7'h67;
  localparam logic [6:0] OP_LUI     = 7'h37;
  localparam logic [6:0] OP_AUIPC   = 7'h17;
  localparam logic [6:0] OP_SYSTEM  = 7'h73;

  localparam logic signed [31:0] IMM_I_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_I_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX = 32'sd4095;
  localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX = 32'sd1048575;

  function automatic logic [6:0] kind_opcode(input logic [3:0] kind);
    case (kind)
      K_R:       return OP_R;
      K_I_ARITH: return OP_I_ARITH;
      K_LOAD:    return OP_LOAD;
      K_STORE:   return OP_STORE;
      K_BRANCH:  return OP_BRANCH;
      K_JAL:     return OP_JAL;
      K_JALR:    return OP_JALR;
      K_LUI:     return OP_LUI;
      K_AUIPC:   return OP_AUIPC;
      K_SYSTEM:  return OP_SYSTEM;
      default:   return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Command stream and memory write port of the program loader.
interface program_loader_if;
  import rv_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        in_last;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  // The loader is the slave of the command stream and master of memory.
  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
    input  in_imm, in_last, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
    output in_imm, in_last, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv_instr_encode.sv
// Combinational RV32I encoder: packs command fields into one instruction word
// and flags immediates the chosen format cannot represent.
module rv_instr_encode
  import rv_pkg::*;
(
  input  logic [3:0]         kind,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic signed [31:0] imm,
  output logic [31:0]        word,
  output logic               range_err,
  output logic               kind_err
);

  logic [6:0] opcode;
  assign opcode = kind_opcode(kind);

  always_comb begin
    word      = '0;
    range_err = 1'b0;
    kind_err  = 1'b0;
    case (kind)
      K_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      K_I_ARITH, K_LOAD, K_JALR, K_SYSTEM: begin
        word      = {imm[11:0], rs1, funct3, rd, opcode};
        range_err = (imm < IMM_I_MIN) || (imm > IMM_I_MAX);
      end
      K_STORE: begin
        word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_err = (imm < IMM_I_MIN) || (imm > IMM_I_MAX);
      end
      K_BRANCH: begin
        word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_err = (imm < IMM_B_MIN) || (imm > IMM_B_MAX) || imm[0];
      end
      K_JAL: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_err = (imm < IMM_J_MIN) || (imm > IMM_J_MAX) || imm[0];
      end
      K_LUI, K_AUIPC: begin
        word      = {imm[31:12], rd, opcode};
        range_err = (imm[11:0] != 12'd0);
      end
      default: kind_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// Streams encoded RV32I words into memory from base_addr upward; rejected
// commands are consumed silently and leave a sticky error.
module program_loader
  import rv_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [31:0]             base_addr,
  program_loader_if.slave         bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [31:0] load_base;
  logic        vld_p1;
  logic [31:0] wdata_p1;
  logic [31:0] enc_word;
  logic        range_err;
  logic        kind_err;
  logic        bad;
  logic        accept;
  logic        wr;

  rv_instr_encode u_encode (
    .kind      (bus.in_kind),
    .rd        (bus.in_rd),
    .rs1       (bus.in_rs1),
    .rs2       (bus.in_rs2),
    .funct3    (bus.in_funct3),
    .funct7    (bus.in_funct7),
    .imm       (bus.in_imm),
    .word      (enc_word),
    .range_err (range_err),
    .kind_err  (kind_err)
  );

  assign bad          = range_err || kind_err;
  assign wr           = vld_p1 && bus.mem_ready;
  assign bus.in_ready = (state == S_LOAD) && (!vld_p1 || bus.mem_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Address tracks the written-word count, so a stalled word keeps its address.
  assign bus.mem_we    = vld_p1;
  assign bus.mem_wdata = wdata_p1;
  assign bus.mem_addr  = load_base + {14'd0, count, 2'b00};
  assign busy          = (state == S_LOAD) || (state == S_DRAIN);
  assign done          = (state == S_DONE);

  // Stage p1: registered output word and load control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      load_base <= '0;
      vld_p1    <= 1'b0;
      wdata_p1  <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_LOAD;
            load_base <= base_addr;
            count     <= '0;
            err       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept && bus.in_last)
            state <= (bad && !vld_p1) ? S_DONE : S_DRAIN;
        end
        S_DRAIN: begin
          if (!vld_p1 || bus.mem_ready)
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase

      if (accept && bad)
        err <= 1'b1;

      if (accept && !bad) begin
        vld_p1   <= 1'b1;
        wdata_p1 <= enc_word;
      end else if (wr) begin
        vld_p1 <= 1'b0;
      end

      if (wr)
        count <= count + 16'd1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised and directed bench for program_loader against an arithmetic
// reference of the RV32I packing rules and a queue of expected writes.
module tb_program_loader;

  typedef struct packed {
    bit [3:0]  kind;
    bit [4:0]  rd;
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit [2:0]  f3;
    bit [6:0]  f7;
    bit [31:0] imm;
    bit        last;
  } cmd_t;

  localparam int QN = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        busy, done, err;
  logic [15:0] count;

  program_loader_if bus ();

  program_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit [31:0]   exp_addr [QN];
  bit [31:0]   exp_data [QN];
  int          wr_idx = 0;
  int          rd_idx = 0;
  bit [31:0]   log_addr [QN];
  bit [31:0]   log_data [QN];
  int          n_wr = 0;
  bit [31:0]   exp_base;
  int          good;
  bit          exp_err;
  int          ready_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic void ref_encode(input cmd_t c, output bit [31:0] w, output bit bad);
    longint s;
    bit [31:0] base;
    s = longint'($signed(c.imm));
    base = 32'(c.rs1) * 32'h8000 + 32'(c.f3) * 32'h1000;
    w = 0;
    bad = 0;
    case (c.kind)
      4'd0: w = 32'(c.f7) * 32'h0200_0000 + 32'(c.rs2) * 32'h10_0000 + base + 32'(c.rd) * 128 + 32'h33;
      4'd1, 4'd2, 4'd6, 4'd9: begin
        bad = (s < -2048) || (s > 2047);
        w = (c.imm % 4096) * 32'h10_0000 + base + 32'(c.rd) * 128;
        w += (c.kind == 1) ? 32'h13 : (c.kind == 2) ? 32'h03 : (c.kind == 6) ? 32'h67 : 32'h73;
      end
      4'd3: begin
        bad = (s < -2048) || (s > 2047);
        w = ((c.imm / 32) % 128) * 32'h0200_0000 + 32'(c.rs2) * 32'h10_0000 + base
            + (c.imm % 32) * 128 + 32'h23;
      end
      4'd4: begin
        bad = (s < -4096) || (s > 4095) || (c.imm % 2 == 1);
        w = ((c.imm / 4096) % 2) * 32'h8000_0000 + ((c.imm / 32) % 64) * 32'h0200_0000
            + 32'(c.rs2) * 32'h10_0000 + base + ((c.imm / 2) % 16) * 256
            + ((c.imm / 2048) % 2) * 128 + 32'h63;
      end
      4'd5: begin
        bad = (s < -1048576) || (s > 1048575) || (c.imm % 2 == 1);
        w = ((c.imm / 32'h10_0000) % 2) * 32'h8000_0000 + ((c.imm / 2) % 1024) * 32'h20_0000
            + ((c.imm / 2048) % 2) * 32'h10_0000 + ((c.imm / 4096) % 256) * 4096
            + 32'(c.rd) * 128 + 32'h6F;
      end
      4'd7, 4'd8: begin
        bad = (c.imm % 4096) != 0;
        w = (c.imm / 4096) * 4096 + 32'(c.rd) * 128 + ((c.kind == 7) ? 32'h37 : 32'h17);
      end
      default: bad = 1;
    endcase
  endfunction

  function automatic cmd_t mk(input bit [3:0] kind, input bit [4:0] rd, input bit [4:0] rs1,
                              input bit [4:0] rs2, input bit [31:0] imm, input bit last);
    cmd_t c;
    c.kind = kind; c.rd = rd; c.rs1 = rs1; c.rs2 = rs2;
    c.f3 = 0; c.f7 = 0; c.imm = imm; c.last = last;
    return c;
  endfunction

  function automatic cmd_t rand_cmd(input bit last);
    cmd_t c;
    c.kind = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    c.rd = 5'($urandom); c.rs1 = 5'($urandom); c.rs2 = 5'($urandom);
    c.f3 = 3'($urandom); c.f7 = 7'($urandom); c.last = last;
    case ($urandom_range(0, 4))
      0: c.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: c.imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      2: c.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
      3: c.imm = $urandom & 32'hFFFF_F000;
      default: c.imm = $urandom;
    endcase
    return c;
  endfunction

  task automatic send(input cmd_t c);
    bit [31:0] w;
    bit bad;
    int n = 0;
    bus.in_kind = c.kind; bus.in_rd = c.rd; bus.in_rs1 = c.rs1; bus.in_rs2 = c.rs2;
    bus.in_funct3 = c.f3; bus.in_funct7 = c.f7; bus.in_imm = c.imm; bus.in_last = c.last;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    ref_encode(c, w, bad);
    if (bad) exp_err = 1;
    else begin
      exp_addr[wr_idx % QN] = exp_base + 32'(good) * 4;
      exp_data[wr_idx % QN] = w;
      wr_idx++;
      good++;
    end
  endtask

  task automatic start_load(input bit [31:0] b);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_base = b; good = 0; exp_err = 0;
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
    check("start_count", 32'(count), 32'd0);
    check("start_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_count"}, 32'(count), 32'(good) & 32'hFFFF);
    check({tag, "_drained"}, 32'(rd_idx), 32'(wr_idx));
  endtask

  task automatic ready_gen();
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.mem_ready = 1'b1;
        1: bus.mem_ready = ($urandom_range(0, 3) != 0);
        default: bus.mem_ready = 1'b0;
      endcase
    end
  endtask

  task automatic monitor();
    bit prev_st = 0;
    bit [31:0] pa = 0, pd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_st = 0;
        rd_idx = wr_idx;
      end else begin
        if (prev_st) begin
          check("hold_we", 32'(bus.mem_we), 32'd1);
          check("hold_addr", bus.mem_addr, pa);
          check("hold_data", bus.mem_wdata, pd);
        end
        if (bus.mem_we && !bus.mem_ready)
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        if (bus.mem_we && bus.mem_ready) begin
          if (rd_idx < wr_idx) begin
            check("wr_addr", bus.mem_addr, exp_addr[rd_idx % QN]);
            check("wr_data", bus.mem_wdata, exp_data[rd_idx % QN]);
            rd_idx++;
          end else begin
            check("spurious_write", 32'd1, 32'd0);
          end
          log_addr[n_wr % QN] = bus.mem_addr;
          log_data[n_wr % QN] = bus.mem_wdata;
          n_wr++;
        end
        prev_st = bus.mem_we && !bus.mem_ready;
        pa = bus.mem_addr;
        pd = bus.mem_wdata;
      end
    end
  endtask

  initial begin
    int w0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0; bus.in_last = 1'b0;
    exp_base = 0; good = 0; exp_err = 0;
    fork
      ready_gen();
      monitor();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;

    // ADDI then ADD, with a stray start mid-load that must be ignored
    w0 = n_wr;
    start_load(32'h100);
    send(mk(4'd1, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0));
    start = 1'b1; base_addr = 32'hDEAD_0000;
    send(mk(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1));
    start = 1'b0;
    wait_done("basic");
    check("basic_w0", log_data[w0 % QN], 32'h0050_0093);
    check("basic_a0", log_addr[w0 % QN], 32'h100);
    check("basic_w1", log_data[(w0 + 1) % QN], 32'h0020_81B3);
    check("basic_a1", log_addr[(w0 + 1) % QN], 32'h104);

    w0 = n_wr;
    start_load(32'h2000);
    send(mk(4'd4, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0));
    send(mk(4'd5, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0));
    send(mk(4'd7, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1));
    wait_done("fmt");
    check("fmt_branch", log_data[w0 % QN], 32'h0020_8463);
    check("fmt_jal", log_data[(w0 + 1) % QN], 32'hFFDF_F0EF);
    check("fmt_lui", log_data[(w0 + 2) % QN], 32'h1234_52B7);

    // Three-cycle memory stall in the middle of a back-to-back stream
    start_load(32'h500);
    fork
      for (int i = 0; i < 6; i++) send(mk(4'd1, 5'(i + 1), 5'd0, 5'd0, 32'(i * 3), i == 5));
      begin
        repeat (2) @(posedge clk);
        ready_mode = 2;
        repeat (3) @(posedge clk);
        ready_mode = 0;
      end
    join
    wait_done("stall");

    w0 = n_wr;
    start_load(32'h400);
    send(mk(4'd12, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0));
    send(mk(4'd4, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0));
    send(mk(4'd1, 5'd2, 5'd0, 5'd0, 32'd7, 1'b1));
    wait_done("errs");
    check("errs_count", 32'(count), 32'd1);
    check("errs_err", 32'(err), 32'd1);
    check("errs_a0", log_addr[w0 % QN], 32'h400);
    check("errs_w0", log_data[w0 % QN], 32'h0070_0113);

    start_load(32'h600);
    send(mk(4'd15, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1));
    wait_done("badlast");

    // Reset while a word is stalled on the memory port
    ready_mode = 2;
    start_load(32'h200);
    send(mk(4'd1, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0));
    @(negedge clk);
    check("pre_rst_we", 32'(bus.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_addr", bus.mem_addr, 32'd0);
    ready_mode = 0;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    w0 = n_wr;
    start_load(32'h3000);
    send(mk(4'd1, 5'd4, 5'd0, 5'd0, 32'd9, 1'b1));
    wait_done("post_rst");
    check("post_rst_a0", log_addr[w0 % QN], 32'h3000);
    check("post_rst_n", 32'(n_wr - w0), 32'd1);

    for (int l = 0; l < 5; l++) begin
      int n;
      ready_mode = 1;
      start_load((l == 0) ? 32'hFFFF_FFF0 : $urandom);
      n = $urandom_range(10, 30);
      for (int i = 0; i < n; i++) send(rand_cmd(i == n - 1));
      wait_done("rand");
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
